// File: rtl/gray_arb_pkg.sv
// Shared types and helpers for the Gray-conversion arbiter.
// bin2gray_f doubles as the reference conversion for benches.
package gray_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_VEC_W   = 4;
    localparam int MAX_VEC_W   = 32;

    // Requester index width; never below one bit so ports stay legal.
    function automatic int id_w_f(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_VEC_W-1:0] bin2gray_f(
        input logic [MAX_VEC_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/Bin2Gray.sv
// Combinational binary-to-Gray converter.
// Shared by all requesters behind the arbiter mux.
module Bin2Gray #(
    parameter int VEC_W = 4
) (
    input  logic [VEC_W-1:0] bin_i,
    output logic [VEC_W-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/rr_picker.sv
// Round-robin picker: first valid at or after ptr, wrapping.
// Produces a one-hot grant, its index and an any-valid flag.
module rr_picker
    import gray_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int ID_W    = id_w_f(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    logic found;
    int   k;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (int'(ptr) + i) % NUM_REQ;
            if (!found && valid[k]) begin
                found    = 1'b1;
                grant[k] = 1'b1;
                idx      = ID_W'(k);
            end
        end
    end

    assign any = found;

endmodule

// File: rtl/gray_conv_arbiter.sv
// Round-robin shared Bin2Gray converter with one registered
// output stage carrying gray, original binary and requester id.
module gray_conv_arbiter
    import gray_arb_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int VEC_W   = DEF_VEC_W,
    localparam int ID_W    = id_w_f(NUM_REQ)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*VEC_W-1:0] req_bin_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [VEC_W-1:0]         rsp_gray_o,
    output logic [VEC_W-1:0]         rsp_bin_o,
    output logic [ID_W-1:0]          rsp_id_o
);

    state_e             state_q;
    logic [ID_W-1:0]    ptr_q;
    logic [VEC_W-1:0]   gray_q;
    logic [VEC_W-1:0]   bin_q;
    logic [ID_W-1:0]    id_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    win_idx;
    logic               any_valid;
    logic               can_accept;
    logic               xfer;
    logic [VEC_W-1:0]   win_bin;
    logic [VEC_W-1:0]   win_gray;
    logic [ID_W-1:0]    ptr_nxt;

    rr_picker #(
        .NUM_REQ(NUM_REQ)
    ) u_picker (
        .valid(req_valid_i),
        .ptr  (ptr_q),
        .grant(grant),
        .idx  (win_idx),
        .any  (any_valid)
    );

    // Draining and refilling in one cycle keeps full throughput.
    assign can_accept = (state_q == ST_EMPTY) || rsp_ready_i;

    always_comb begin
        req_ready_o = '0;
        if (!reset_i && can_accept && any_valid) begin
            req_ready_o = grant;
        end
    end

    assign xfer = |(req_valid_i & req_ready_o);

    always_comb begin
        win_bin = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_bin = req_bin_i[i*VEC_W +: VEC_W];
            end
        end
    end

    Bin2Gray #(
        .VEC_W(VEC_W)
    ) u_b2g (
        .bin_i (win_bin),
        .gray_o(win_gray)
    );

    assign ptr_nxt = (win_idx == ID_W'(NUM_REQ - 1))
                   ? '0 : win_idx + 1'b1;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            gray_q  <= '0;
            bin_q   <= '0;
            id_q    <= '0;
        end else if (xfer) begin
            state_q <= ST_FULL;
            ptr_q   <= ptr_nxt;
            gray_q  <= win_gray;
            bin_q   <= win_bin;
            id_q    <= win_idx;
        end else if (state_q == ST_FULL && rsp_ready_i) begin
            state_q <= ST_EMPTY;
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_gray_o  = gray_q;
    assign rsp_bin_o   = bin_q;
    assign rsp_id_o    = id_q;

endmodule
